// File: rtl/decoder_rr_sched_pkg.sv
// -----------------------------------------------------------------------------
// decoder_rr_sched_pkg
// Shared constants and helpers for the round-robin decoder scheduler slice.
//   DEC_CODE_W : width of one decoder code (matches io_in)
//   DEC_OUT_W  : width of the decoder output word
//   id_width() : tag width for a requester count, never below one bit
// -----------------------------------------------------------------------------
package decoder_rr_sched_pkg;

    localparam int DEC_CODE_W = 7;
    localparam int DEC_OUT_W  = 8;

    // Tag width for n requesters; a single-bit tag is kept even for n <= 2.
    function automatic int id_width(input int n);
        int w;
        if (n <= 2) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage : decoder_rr_sched_pkg

// File: rtl/decoder_rr_sched_if.sv
// -----------------------------------------------------------------------------
// decoder_rr_sched_if
// Request/response bundle between the requesters, the consumer and the
// scheduler.
//   req_valid / req_ready : per-requester handshake (ready is one-hot)
//   req_code              : requester i code at [i*CODE_W +: CODE_W]
//   rsp_valid / rsp_ready : backpressured response handshake
//   rsp_data / rsp_id     : decoded word and originating requester index
// Modports: slave = scheduler side, master = requester/consumer side.
// -----------------------------------------------------------------------------
interface decoder_rr_sched_if
    import decoder_rr_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CODE_W  = DEC_CODE_W,
    parameter int OUT_W   = DEC_OUT_W
) ();

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*CODE_W-1:0] req_code;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [OUT_W-1:0]          rsp_data;
    logic [ID_W-1:0]           rsp_id;

    modport slave (
        input  req_valid,
        input  req_code,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_id
    );

    modport master (
        output req_valid,
        output req_code,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_id
    );

endinterface : decoder_rr_sched_if

// File: rtl/decoder_rr_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_rr_sched_rr_arbiter
// Purely combinational round-robin pick: first asserted request scanning
// upward from ptr, wrapping modulo NUM_REQ.
//   ptr       : in  ID_W     highest-priority index for this cycle
//   req       : in  NUM_REQ  request vector
//   grant     : out NUM_REQ  one-hot winner (all-zero when nothing requests)
//   grant_idx : out ID_W     binary index of the winner
//   grant_any : out 1        some request won
// -----------------------------------------------------------------------------
module decoder_rr_sched_rr_arbiter
    import decoder_rr_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [ID_W-1:0]    ptr,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam logic [ID_W:0] NUM_L = (ID_W+1)'(NUM_REQ);

    logic [ID_W:0]   sum_s;
    logic [ID_W-1:0] cand_s;

    // Priority scan starting at ptr; the first hit wins and later hits are ignored.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum_s     = '0;
        cand_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s  = {1'b0, ptr} + (ID_W+1)'(i);
            sum_s  = (sum_s >= NUM_L) ? (sum_s - NUM_L) : sum_s;
            cand_s = sum_s[ID_W-1:0];
            if (!grant_any && req[cand_s]) begin
                grant_any        = 1'b1;
                grant_idx        = cand_s;
                grant[cand_s]    = 1'b1;
            end else begin
                // earlier winner (or no request) stands
            end
        end
    end

endmodule : decoder_rr_sched_rr_arbiter

// File: rtl/decoder_rr_sched.sv
// -----------------------------------------------------------------------------
// decoder_rr_sched
// Shares one combinational decoder between NUM_REQ requesters. A round-robin
// arbiter accepts one code per cycle into stage 1, which drives the shared
// decoder from a register; stage 2 captures the decoder result and presents
// it on a single backpressured response port tagged with the requester id.
//   clock    : in  1        rising-edge clock
//   reset    : in  1        synchronous, active-high
//   bus      : slave modport of decoder_rr_sched_if (requests + response)
//   dec_in   : out CODE_W   registered code to the shared decoder
//   dec_out  : in  OUT_W    decoder result, combinational from dec_in
//   busy     : out 1        either stage holds a code/result
// -----------------------------------------------------------------------------
module decoder_rr_sched
    import decoder_rr_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int CODE_W  = DEC_CODE_W,
    parameter  int OUT_W   = DEC_OUT_W,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    decoder_rr_sched_if.slave       bus,
    output logic [CODE_W-1:0]       dec_in,
    input  logic [OUT_W-1:0]        dec_out,
    output logic                    busy
);

    // Stage 1: code in front of the decoder.
    logic              s1_v_r;
    logic [CODE_W-1:0] dec_in_r;
    logic [ID_W-1:0]   s1_id_r;
    // Stage 2: captured response.
    logic              rsp_valid_r;
    logic [OUT_W-1:0]  rsp_data_r;
    logic [ID_W-1:0]   rsp_id_r;
    // Arbitration state and status.
    logic [ID_W-1:0]   ptr_r;
    logic              busy_r;

    logic              s2_free_s;
    logic              s1_free_s;
    logic [NUM_REQ-1:0] grant_raw_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic              grant_any_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic              xfer_s;
    logic [CODE_W-1:0] sel_code_s;
    logic [ID_W-1:0]   ptr_nxt_s;
    logic              s1_v_nxt_s;
    logic              rsp_valid_nxt_s;

    decoder_rr_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .ptr       (ptr_r),
        .req       (bus.req_valid),
        .grant     (grant_raw_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // Handshake, stage-advance and next-state decisions for both stages.
    always_comb begin
        s2_free_s = !rsp_valid_r || bus.rsp_ready;
        s1_free_s = !s1_v_r || s2_free_s;

        // Grant only while stage 1 can take a code; suppressed during reset so
        // no requester sees a handshake that the reset would discard.
        if (s1_free_s && grant_any_s && !reset) begin
            req_ready_s = grant_raw_s;
        end else begin
            req_ready_s = '0;
        end
        xfer_s = |req_ready_s;

        // Constant-base mux keeps the code select free of computed part-selects.
        sel_code_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready_s[i]) begin
                sel_code_s = bus.req_code[i*CODE_W +: CODE_W];
            end else begin
                // not the granted requester
            end
        end

        if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = grant_idx_s + 1'b1;
        end

        if (xfer_s) begin
            s1_v_nxt_s = 1'b1;
        end else if (s1_free_s) begin
            s1_v_nxt_s = 1'b0;
        end else begin
            s1_v_nxt_s = s1_v_r;
        end

        // When stage 2 drains or is empty it takes whatever stage 1 holds.
        if (s2_free_s) begin
            rsp_valid_nxt_s = s1_v_r;
        end else begin
            rsp_valid_nxt_s = rsp_valid_r;
        end
    end

    // Pipeline registers, round-robin pointer and busy flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_v_r      <= 1'b0;
            dec_in_r    <= '0;
            s1_id_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_id_r    <= '0;
            ptr_r       <= '0;
            busy_r      <= 1'b0;
        end else begin
            // dec_in is left holding its last code when stage 1 empties so the
            // shared decoder input does not toggle needlessly.
            if (xfer_s) begin
                dec_in_r <= sel_code_s;
                s1_id_r  <= grant_idx_s;
                ptr_r    <= ptr_nxt_s;
            end else begin
                dec_in_r <= dec_in_r;
                s1_id_r  <= s1_id_r;
                ptr_r    <= ptr_r;
            end
            s1_v_r <= s1_v_nxt_s;

            if (s2_free_s && s1_v_r) begin
                rsp_data_r <= dec_out;
                rsp_id_r   <= s1_id_r;
            end else begin
                rsp_data_r <= rsp_data_r;
                rsp_id_r   <= rsp_id_r;
            end
            rsp_valid_r <= rsp_valid_nxt_s;

            busy_r <= s1_v_nxt_s | rsp_valid_nxt_s;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_id    = rsp_id_r;
    assign dec_in        = dec_in_r;
    assign busy          = busy_r;

endmodule : decoder_rr_sched

// File: tb/tb_decoder_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_decoder_rr_sched
// Self-checking bench for decoder_rr_sched with NUM_REQ = 4. A stand-in
// decoder function drives dec_out. A transaction-level model (queue of
// in-flight codes with their age, plus a rotating pointer) predicts grants,
// responses, dec_in and busy.
// -----------------------------------------------------------------------------
module tb_decoder_rr_sched;

    localparam int NREQ = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*7-1:0] req_code;
    logic             rsp_ready;
    logic [6:0]       dec_in;
    logic [7:0]       dec_out;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    decoder_rr_sched_if #(.NUM_REQ(NREQ), .CODE_W(7), .OUT_W(8)) bus ();

    assign bus.req_valid = req_valid;
    assign bus.req_code  = req_code;
    assign bus.rsp_ready = rsp_ready;

    decoder_rr_sched #(.NUM_REQ(NREQ)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .dec_in  (dec_in),
        .dec_out (dec_out),
        .busy    (busy)
    );

    // Stand-in for the shared decoder.
    function automatic logic [7:0] dec_fn(input logic [6:0] c);
        return {c[2:0], c[6:3], ^c} ^ 8'h3C;
    endfunction

    assign dec_out = dec_fn(dec_in);

    // ---------------- reference model ----------------
    int          q_id[$];
    logic [7:0]  q_data[$];
    int          q_age[$];
    int          m_ptr  = 0;
    logic [6:0]  m_last = 7'd0;

    logic [NREQ-1:0] e_ready;
    int              e_g;
    logic            e_rv;
    int              e_id;
    logic [7:0]      e_data;
    logic            e_busy;

    // At most two codes are in flight; the head is visible once it has aged an edge.
    task automatic model_eval();
        logic ok;
        e_rv = (q_id.size() > 0) && (q_age[0] >= 1);
        ok   = !reset && ((q_id.size() < 2) || (e_rv && rsp_ready));
        e_ready = '0;
        e_g     = -1;
        if (ok) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (e_g < 0 && req_valid[idx]) begin
                    e_g = idx;
                    e_ready[idx] = 1'b1;
                end
            end
        end
        e_id   = e_rv ? q_id[0] : 0;
        e_data = e_rv ? q_data[0] : 8'h00;
        e_busy = (q_id.size() > 0);
    endtask

    // One clock: predict from pre-edge inputs, update the model at the edge,
    // return on the following falling edge.
    task automatic advance();
        model_eval();
        @(posedge clock);
        if (reset) begin
            q_id.delete();
            q_data.delete();
            q_age.delete();
            m_ptr  = 0;
            m_last = 7'd0;
        end else begin
            if (e_rv && rsp_ready) begin
                void'(q_id.pop_front());
                void'(q_data.pop_front());
                void'(q_age.pop_front());
            end
            foreach (q_age[k]) q_age[k] = q_age[k] + 1;
            if (e_g >= 0) begin
                q_id.push_back(e_g);
                q_data.push_back(dec_fn(req_code[e_g*7 +: 7]));
                q_age.push_back(0);
                m_ptr  = (e_g + 1) % NREQ;
                m_last = req_code[e_g*7 +: 7];
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        advance();
        reset     = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'hF;
        req_code  = 28'($urandom);
        rsp_ready = 1'b1;
        advance();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.req_ready !== 4'h0) begin
                errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
            end
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid);
            end
            checks++;
            if (dec_in !== 7'd0 || busy !== 1'b0) begin
                errors++; $display("FAIL reset_dec_in_busy: got %h/%b expected 00/0", dec_in, busy);
            end
            checks++;
            if (bus.rsp_data !== 8'h00 || bus.rsp_id !== 2'd0) begin
                errors++; $display("FAIL reset_rsp_fields: got %h/%0d expected 00/0", bus.rsp_data, bus.rsp_id);
            end
            advance();
        end
        reset     = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        logic [6:0] code;
        code      = 7'b1011000;
        req_code  = 28'($urandom);
        req_code[6:0] = code;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL single_grant: got %b expected 0001", bus.req_ready);
        end
        advance();
        req_valid = '0;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || dec_in !== code) begin
            errors++; $display("FAIL single_stage1: got rv=%b dec_in=%h expected rv=0 dec_in=%h", bus.rsp_valid, dec_in, code);
        end
        advance();
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== dec_fn(code)) begin
            errors++; $display("FAIL single_rsp: got rv=%b id=%0d data=%h expected rv=1 id=0 data=%h",
                               bus.rsp_valid, bus.rsp_id, bus.rsp_data, dec_fn(code));
        end
        advance();
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || dec_in !== code) begin
            errors++; $display("FAIL single_drain: got rv=%b busy=%b dec_in=%h expected 0/0/%h", bus.rsp_valid, busy, dec_in, code);
        end
    endtask

    task automatic test_fairness();
        logic [6:0]      sent[12];
        logic [NREQ-1:0] exp_g;
        do_reset();
        rsp_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            req_code  = 28'($urandom);
            req_valid = (c < 12) ? 4'hF : 4'h0;
            #1;
            if (c < 12) begin
                exp_g   = 4'(1 << (c % 4));
                sent[c] = req_code[(c % 4)*7 +: 7];
                checks++;
                if (bus.req_ready !== exp_g) begin
                    errors++; $display("FAIL fair_grant[%0d]: got %b expected %b", c, bus.req_ready, exp_g);
                end
            end
            if (c >= 2) begin
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'((c - 2) % 4) || bus.rsp_data !== dec_fn(sent[c-2])) begin
                    errors++; $display("FAIL fair_rsp[%0d]: got rv=%b id=%0d data=%h expected rv=1 id=%0d data=%h",
                                       c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, (c - 2) % 4, dec_fn(sent[c-2]));
                end
            end
            advance();
        end
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL fair_end: got rv=%b expected 0", bus.rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [6:0]      code1, code2;
        logic [7:0]      held;
        logic [NREQ-1:0] exp_g;
        int              accepted;
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        accepted  = 0;
        held      = 8'h00;
        code1     = 7'd0;
        code2     = 7'd0;
        for (int c = 0; c < 5; c++) begin
            req_code = 28'($urandom);
            #1;
            if (c == 0) code1 = req_code[13:7];
            if (c == 1) code2 = req_code[20:14];
            accepted += $countones(bus.req_ready & req_valid);
            exp_g = (c == 0) ? 4'b0010 : ((c == 1) ? 4'b0100 : 4'b0000);
            checks++;
            if (bus.req_ready !== exp_g) begin
                errors++; $display("FAIL bp_grant[%0d]: got %b expected %b", c, bus.req_ready, exp_g);
            end
            if (c == 2) held = bus.rsp_data;
            if (c >= 2) begin
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== dec_fn(code1) || bus.rsp_data !== held) begin
                    errors++; $display("FAIL bp_hold[%0d]: got rv=%b id=%0d data=%h expected rv=1 id=1 data=%h",
                                       c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, dec_fn(code1));
                end
            end
            advance();
        end
        checks++;
        if (accepted !== 2) begin
            errors++; $display("FAIL bp_accepted: got %0d expected 2", accepted);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== dec_fn(code1)) begin
            errors++; $display("FAIL bp_release1: got rv=%b id=%0d data=%h expected rv=1 id=1 data=%h",
                               bus.rsp_valid, bus.rsp_id, bus.rsp_data, dec_fn(code1));
        end
        advance();
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== dec_fn(code2)) begin
            errors++; $display("FAIL bp_release2: got rv=%b id=%0d data=%h expected rv=1 id=2 data=%h",
                               bus.rsp_valid, bus.rsp_id, bus.rsp_data, dec_fn(code2));
        end
        advance();
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_empty: got rv=%b expected 0", bus.rsp_valid);
        end
    endtask

    // Follows test_backpressure: last grant went to 2, so the pointer sits at 3.
    task automatic test_wrap();
        rsp_ready = 1'b1;
        req_valid = 4'b0101;
        req_code  = 28'($urandom);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL wrap_first: got %b expected 0001", bus.req_ready);
        end
        advance();
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++; $display("FAIL wrap_second: got %b expected 0100", bus.req_ready);
        end
        advance();
        req_valid = '0;
        repeat (3) advance();
    endtask

    task automatic test_mid_reset();
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        req_code  = 28'($urandom);
        advance();
        advance();
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || busy !== 1'b1 || bus.req_ready !== 4'h0) begin
            errors++; $display("FAIL mid_full: got rv=%b busy=%b ready=%b expected 1/1/0000", bus.rsp_valid, busy, bus.req_ready);
        end
        reset = 1'b1;
        advance();
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_cleared: got rv=%b busy=%b expected 0/0", bus.rsp_valid, busy);
        end
        for (int c = 0; c < 4; c++) begin
            advance();
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++; $display("FAIL mid_stale[%0d]: got rv=%b expected 0", c, bus.rsp_valid);
            end
        end
        req_valid = 4'hF;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL mid_ptr: got %b expected 0001", bus.req_ready);
        end
        advance();
        req_valid = '0;
        repeat (3) advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 63) == 0);
            req_valid = 4'($urandom);
            req_code  = 28'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            model_eval();
            checks++;
            if (bus.req_ready !== e_ready) begin
                errors++; $display("FAIL rnd_grant[%0d]: got %b expected %b", c, bus.req_ready, e_ready);
            end
            checks++;
            if (bus.rsp_valid !== e_rv) begin
                errors++; $display("FAIL rnd_rsp_valid[%0d]: got %b expected %b", c, bus.rsp_valid, e_rv);
            end
            if (e_rv) begin
                checks++;
                if (bus.rsp_id !== 2'(e_id) || bus.rsp_data !== e_data) begin
                    errors++; $display("FAIL rnd_rsp[%0d]: got id=%0d data=%h expected id=%0d data=%h",
                                       c, bus.rsp_id, bus.rsp_data, e_id, e_data);
                end
            end
            checks++;
            if (dec_in !== m_last || busy !== e_busy) begin
                errors++; $display("FAIL rnd_dec_busy[%0d]: got dec_in=%h busy=%b expected %h/%b", c, dec_in, busy, m_last, e_busy);
            end
            advance();
        end
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) advance();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_code  = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_decoder_rr_sched
